ex_forward_source: RTL and testbench

Producer side of the EX1 forwarding bus. Holds the destination-register tags, result data and data-valid bits for the dual-issue instruction pairs in the MB_EX, EX1_EX2 and EX2_WB pipeline registers, and presents them to the EX1 forwarding unit. It advances under EX1/EX2 stall control, inserts bubbles, accepts late EX2 result fills (load/mul) while stalled, clears on flush, and emits the two write-back requests from the EX2_WB slot.

---
 rtl/ex_forward_source.sv | 158 +++++++++++++++
 tb/tb_ex_forward_source.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_forward_source.sv
// Producer side of the EX1 forwarding bus: tags, results and ready bits for the
// MB_EX, EX1_EX2 and EX2_WB dual-issue slots, plus the two write-back requests.
module ex_forward_source #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rd0,
    input  logic [4:0]        id_rd1,
    input  logic [1:0]        id_ready,
    input  logic [DATA_W-1:0] id_data0,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [1:0]        ex1_res_valid,
    input  logic [DATA_W-1:0] ex1_res0,
    input  logic [DATA_W-1:0] ex1_res1,
    input  logic [1:0]        ex2_fill_valid,
    input  logic [DATA_W-1:0] ex2_fill0,
    input  logic [DATA_W-1:0] ex2_fill1,
    input  logic              ex1_stall,
    input  logic              ex2_stall,
    input  logic              flush,
    output logic [4:0]        mb_ex_rd0,
    output logic [4:0]        mb_ex_rd1,
    output logic [4:0]        ex1_ex2_rd0,
    output logic [4:0]        ex1_ex2_rd1,
    output logic [4:0]        ex2_wb_rd0,
    output logic [4:0]        ex2_wb_rd1,
    output logic [DATA_W-1:0] mb_ex_data_0,
    output logic [DATA_W-1:0] mb_ex_data_1,
    output logic [DATA_W-1:0] ex1_ex2_data_0,
    output logic [DATA_W-1:0] ex1_ex2_data_1,
    output logic [DATA_W-1:0] ex2_wb_data_0,
    output logic [DATA_W-1:0] ex2_wb_data_1,
    output logic              mb_ex_data_0_valid,
    output logic              mb_ex_data_1_valid,
    output logic              ex1_ex2_data_0_valid,
    output logic              ex1_ex2_data_1_valid,
    output logic              ex2_wb_data_0_valid,
    output logic              ex2_wb_data_1_valid,
    output logic [1:0]        wb_we,
    output logic [4:0]        wb_rd0,
    output logic [4:0]        wb_rd1,
    output logic [DATA_W-1:0] wb_data0,
    output logic [DATA_W-1:0] wb_data1
);

    typedef struct packed {
        logic              lv;
        logic              rdy;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } lane_t;

    typedef lane_t [1:0] slot_t;

    slot_t s0_q, s1_q, s2_q;
    slot_t s0_d, s1_d, s2_d;
    slot_t id_entry, s0_adv, s1_fill;

    logic [1:0][4:0]        id_rd_v;
    logic [1:0][DATA_W-1:0] id_data_v, ex1_res_v, fill_v;

    assign id_rd_v   = {id_rd1, id_rd0};
    assign id_data_v = {id_data1, id_data0};
    assign ex1_res_v = {ex1_res1, ex1_res0};
    assign fill_v    = {ex2_fill1, ex2_fill0};

    // Candidate slot contents: new issue, S0 completed by EX1, S1 completed by EX2.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        id_entry = '0;
        s0_adv   = s0_q;
        s1_fill  = s1_q;
        for (int i = 0; i < 2; i++) begin
            if (id_valid) begin
                id_entry[i].lv   = 1'b1;
                id_entry[i].rd   = id_rd_v[i];
                id_entry[i].rdy  = id_ready[i] | (id_rd_v[i] == 5'd0);
                id_entry[i].data = id_ready[i] ? id_data_v[i] : '0;
            end
            if (s0_q[i].lv && !s0_q[i].rdy && ex1_res_valid[i]) begin
                s0_adv[i].rdy  = 1'b1;
                s0_adv[i].data = ex1_res_v[i];
            end
            if (s1_q[i].lv && !s1_q[i].rdy && ex2_fill_valid[i]) begin
                s1_fill[i].rdy  = 1'b1;
                s1_fill[i].data = fill_v[i];
            end
        end
    end

    // Advance control, highest priority first: flush, ex2_stall, ex1_stall, normal.
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        if (flush) begin
            s0_d = '0;
            s1_d = '0;
            s2_d = ex2_stall ? slot_t'('0) : s1_fill;
        end else if (ex2_stall) begin
            s1_d = s1_fill;
            s2_d = '0;
        end else if (ex1_stall) begin
            s1_d = '0;
            s2_d = s1_fill;
        end else begin
            s0_d = id_entry;
            s1_d = s0_adv;
            s2_d = s1_fill;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all slots update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Empty lanes present tag 0 so the consumer needs no separate valid qualifier.
    assign mb_ex_rd0   = s0_q[0].lv ? s0_q[0].rd : 5'd0;
    assign mb_ex_rd1   = s0_q[1].lv ? s0_q[1].rd : 5'd0;
    assign ex1_ex2_rd0 = s1_q[0].lv ? s1_q[0].rd : 5'd0;
    assign ex1_ex2_rd1 = s1_q[1].lv ? s1_q[1].rd : 5'd0;
    assign ex2_wb_rd0  = s2_q[0].lv ? s2_q[0].rd : 5'd0;
    assign ex2_wb_rd1  = s2_q[1].lv ? s2_q[1].rd : 5'd0;

    assign mb_ex_data_0   = s0_q[0].data;
    assign mb_ex_data_1   = s0_q[1].data;
    assign ex1_ex2_data_0 = s1_q[0].data;
    assign ex1_ex2_data_1 = s1_q[1].data;
    assign ex2_wb_data_0  = s2_q[0].data;
    assign ex2_wb_data_1  = s2_q[1].data;

    assign mb_ex_data_0_valid   = s0_q[0].lv & s0_q[0].rdy;
    assign mb_ex_data_1_valid   = s0_q[1].lv & s0_q[1].rdy;
    assign ex1_ex2_data_0_valid = s1_q[0].lv & s1_q[0].rdy;
    assign ex1_ex2_data_1_valid = s1_q[1].lv & s1_q[1].rdy;
    assign ex2_wb_data_0_valid  = s2_q[0].lv & s2_q[0].rdy;
    assign ex2_wb_data_1_valid  = s2_q[1].lv & s2_q[1].rdy;

    // A lane still unready in S2 is a protocol error and is dropped, not written.
    assign wb_we[0] = s2_q[0].lv & s2_q[0].rdy & (s2_q[0].rd != 5'd0);
    assign wb_we[1] = s2_q[1].lv & s2_q[1].rdy & (s2_q[1].rd != 5'd0);
    assign wb_rd0   = s2_q[0].rd;
    assign wb_rd1   = s2_q[1].rd;
    assign wb_data0 = s2_q[0].data;
    assign wb_data1 = s2_q[1].data;

endmodule

// File: tb/tb_ex_forward_source.sv
// Self-checking bench for ex_forward_source: directed scenarios with literal
// expectations plus randomized traffic against a slot-level behavioural model.
module tb_ex_forward_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rd0 = '0, id_rd1 = '0;
    logic [1:0]  id_ready = '0;
    logic [31:0] id_data0 = '0, id_data1 = '0;
    logic [1:0]  ex1_res_valid = '0;
    logic [31:0] ex1_res0 = '0, ex1_res1 = '0;
    logic [1:0]  ex2_fill_valid = '0;
    logic [31:0] ex2_fill0 = '0, ex2_fill1 = '0;
    logic        ex1_stall = 1'b0, ex2_stall = 1'b0, flush = 1'b0;

    logic [4:0]  mb_ex_rd0, mb_ex_rd1, ex1_ex2_rd0, ex1_ex2_rd1, ex2_wb_rd0, ex2_wb_rd1;
    logic [31:0] mb_ex_data_0, mb_ex_data_1, ex1_ex2_data_0, ex1_ex2_data_1;
    logic [31:0] ex2_wb_data_0, ex2_wb_data_1;
    logic        mb_ex_data_0_valid, mb_ex_data_1_valid, ex1_ex2_data_0_valid;
    logic        ex1_ex2_data_1_valid, ex2_wb_data_0_valid, ex2_wb_data_1_valid;
    logic [1:0]  wb_we;
    logic [4:0]  wb_rd0, wb_rd1;
    logic [31:0] wb_data0, wb_data1;

    ex_forward_source #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rd0(id_rd0), .id_rd1(id_rd1), .id_ready(id_ready),
        .id_data0(id_data0), .id_data1(id_data1),
        .ex1_res_valid(ex1_res_valid), .ex1_res0(ex1_res0), .ex1_res1(ex1_res1),
        .ex2_fill_valid(ex2_fill_valid), .ex2_fill0(ex2_fill0), .ex2_fill1(ex2_fill1),
        .ex1_stall(ex1_stall), .ex2_stall(ex2_stall), .flush(flush),
        .mb_ex_rd0(mb_ex_rd0), .mb_ex_rd1(mb_ex_rd1),
        .ex1_ex2_rd0(ex1_ex2_rd0), .ex1_ex2_rd1(ex1_ex2_rd1),
        .ex2_wb_rd0(ex2_wb_rd0), .ex2_wb_rd1(ex2_wb_rd1),
        .mb_ex_data_0(mb_ex_data_0), .mb_ex_data_1(mb_ex_data_1),
        .ex1_ex2_data_0(ex1_ex2_data_0), .ex1_ex2_data_1(ex1_ex2_data_1),
        .ex2_wb_data_0(ex2_wb_data_0), .ex2_wb_data_1(ex2_wb_data_1),
        .mb_ex_data_0_valid(mb_ex_data_0_valid), .mb_ex_data_1_valid(mb_ex_data_1_valid),
        .ex1_ex2_data_0_valid(ex1_ex2_data_0_valid), .ex1_ex2_data_1_valid(ex1_ex2_data_1_valid),
        .ex2_wb_data_0_valid(ex2_wb_data_0_valid), .ex2_wb_data_1_valid(ex2_wb_data_1_valid),
        .wb_we(wb_we), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
        .wb_data0(wb_data0), .wb_data1(wb_data1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m[slot][lane], slot 0 = MB_EX, 1 = EX1_EX2, 2 = EX2_WB.
    typedef struct packed {
        logic        lv;
        logic        rdy;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t m[3][2];

    function automatic ent_t empty_ent();
        ent_t e;
        e.lv = 1'b0; e.rdy = 1'b0; e.rd = 5'd0; e.data = 32'd0;
        return e;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 2; i++) m[s][i] = empty_ent();
    endtask

    task automatic model_step();
        ent_t issued[2], done0[2], filled1[2];
        if (rst) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            issued[i] = empty_ent();
            if (id_valid) begin
                issued[i].lv   = 1'b1;
                issued[i].rd   = (i == 0) ? id_rd0 : id_rd1;
                issued[i].rdy  = id_ready[i] || issued[i].rd == 0;
                issued[i].data = id_ready[i] ? ((i == 0) ? id_data0 : id_data1) : 32'd0;
            end
            done0[i] = m[0][i];
            if (done0[i].lv && !done0[i].rdy && ex1_res_valid[i]) begin
                done0[i].rdy  = 1'b1;
                done0[i].data = (i == 0) ? ex1_res0 : ex1_res1;
            end
            filled1[i] = m[1][i];
            if (filled1[i].lv && !filled1[i].rdy && ex2_fill_valid[i]) begin
                filled1[i].rdy  = 1'b1;
                filled1[i].data = (i == 0) ? ex2_fill0 : ex2_fill1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                m[2][i] = ex2_stall ? empty_ent() : filled1[i];
                m[1][i] = empty_ent();
                m[0][i] = empty_ent();
            end else if (ex2_stall) begin
                m[2][i] = empty_ent();
                m[1][i] = filled1[i];
            end else if (ex1_stall) begin
                m[2][i] = filled1[i];
                m[1][i] = empty_ent();
            end else begin
                m[2][i] = filled1[i];
                m[1][i] = done0[i];
                m[0][i] = issued[i];
            end
        end
    endtask

    function automatic logic [4:0] dut_tag(input int s, input int i);
        case (s * 2 + i)
            0: return mb_ex_rd0;   1: return mb_ex_rd1;
            2: return ex1_ex2_rd0; 3: return ex1_ex2_rd1;
            4: return ex2_wb_rd0;  default: return ex2_wb_rd1;
        endcase
    endfunction

    function automatic logic [31:0] dut_data(input int s, input int i);
        case (s * 2 + i)
            0: return mb_ex_data_0;   1: return mb_ex_data_1;
            2: return ex1_ex2_data_0; 3: return ex1_ex2_data_1;
            4: return ex2_wb_data_0;  default: return ex2_wb_data_1;
        endcase
    endfunction

    function automatic logic dut_valid(input int s, input int i);
        case (s * 2 + i)
            0: return mb_ex_data_0_valid;   1: return mb_ex_data_1_valid;
            2: return ex1_ex2_data_0_valid; 3: return ex1_ex2_data_1_valid;
            4: return ex2_wb_data_0_valid;  default: return ex2_wb_data_1_valid;
        endcase
    endfunction

    task automatic compare_all();
        logic [1:0] exp_we;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("s%0d_l%0d_tag", s, i), 32'(dut_tag(s, i)),
                      32'(m[s][i].lv ? m[s][i].rd : 5'd0));
                check($sformatf("s%0d_l%0d_data", s, i), dut_data(s, i), m[s][i].data);
                check($sformatf("s%0d_l%0d_valid", s, i), 32'(dut_valid(s, i)),
                      32'(m[s][i].lv & m[s][i].rdy));
            end
        end
        for (int i = 0; i < 2; i++)
            exp_we[i] = m[2][i].lv && m[2][i].rdy && m[2][i].rd != 0;
        check("wb_we", 32'(wb_we), 32'(exp_we));
        check("wb_rd0", 32'(wb_rd0), 32'(m[2][0].rd));
        check("wb_rd1", 32'(wb_rd1), 32'(m[2][1].rd));
        check("wb_data0", wb_data0, m[2][0].data);
        check("wb_data1", wb_data1, m[2][1].data);
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_ready = '0; id_rd0 = '0; id_rd1 = '0; id_data0 = '0; id_data1 = '0;
        ex1_res_valid = '0; ex2_fill_valid = '0; ex1_stall = 0; ex2_stall = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] rdy,
                         input logic [31:0] d0, input logic [31:0] d1);
        id_valid = 1; id_rd0 = r0; id_rd1 = r1; id_ready = rdy; id_data0 = d0; id_data1 = d1;
    endtask

    initial begin
        model_clear();
        idle_inputs();
        repeat (3) tick();
        rst = 0;
        chk_en = 1;
        tick();
        check("reset_wb_we", 32'(wb_we), 32'd0);
        check("reset_mb_rd0", 32'(mb_ex_rd0), 32'd0);

        // Basic flow: lane 0 ready at issue, lane 1 completed by EX1.
        issue(5'd5, 5'd6, 2'b01, 32'h11, 32'h99);
        tick();
        check("t1_mb_rd0", 32'(mb_ex_rd0), 32'd5);
        check("t1_mb_v0", 32'(mb_ex_data_0_valid), 32'd1);
        check("t1_mb_rd1", 32'(mb_ex_rd1), 32'd6);
        check("t1_mb_v1", 32'(mb_ex_data_1_valid), 32'd0);
        idle_inputs();
        ex1_res_valid = 2'b10; ex1_res1 = 32'h22;
        tick();
        check("t1_s1_data1", ex1_ex2_data_1, 32'h22);
        check("t1_s1_v1", 32'(ex1_ex2_data_1_valid), 32'd1);
        idle_inputs();
        tick();
        check("t1_wb_we", 32'(wb_we), 32'd3);
        check("t1_wb_data0", wb_data0, 32'h11);

        // Load in S1 lane 0 filled during an EX2 stall.
        issue(5'd7, 5'd0, 2'b00, 32'h0, 32'h0);
        tick();
        idle_inputs();
        tick();
        check("t2_pre_v0", 32'(ex1_ex2_data_0_valid), 32'd0);
        ex2_stall = 1;
        tick();
        check("t2_st1_v0", 32'(ex1_ex2_data_0_valid), 32'd0);
        check("t2_st1_wb_rd0", 32'(ex2_wb_rd0), 32'd0);
        ex2_fill_valid = 2'b01; ex2_fill0 = 32'hABCD;
        tick();
        check("t2_st2_v0", 32'(ex1_ex2_data_0_valid), 32'd1);
        check("t2_st2_wb_rd0", 32'(ex2_wb_rd0), 32'd0);
        ex2_fill_valid = 2'b00;
        tick();
        check("t2_st3_wb_rd0", 32'(ex2_wb_rd0), 32'd0);
        check("t2_st3_wb_rd1", 32'(ex2_wb_rd1), 32'd0);
        ex2_stall = 0;
        tick();
        check("t2_wb_rd0", 32'(ex2_wb_rd0), 32'd7);
        check("t2_wb_data0", wb_data0, 32'hABCD);
        check("t2_wb_we", 32'(wb_we), 32'd1);

        // EX1 stall holds S0, empties S1, ignores new issue.
        issue(5'd3, 5'd4, 2'b11, 32'h33, 32'h44);
        tick();
        issue(5'd9, 5'd10, 2'b11, 32'h90, 32'hA0);
        ex1_stall = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t3_mb_rd0", 32'(mb_ex_rd0), 32'd3);
            check("t3_mb_rd1", 32'(mb_ex_rd1), 32'd4);
            check("t3_s1_rd0", 32'(ex1_ex2_rd0), 32'd0);
            check("t3_s1_rd1", 32'(ex1_ex2_rd1), 32'd0);
        end
        idle_inputs();
        tick();
        check("t3_rel_s1_rd0", 32'(ex1_ex2_rd0), 32'd3);

        // Flush with S0 and S1 full: old S1 still reaches S2.
        issue(5'd12, 5'd13, 2'b11, 32'hC, 32'hD);
        tick();
        issue(5'd14, 5'd15, 2'b11, 32'hE, 32'hF);
        tick();
        idle_inputs();
        flush = 1;
        tick();
        check("t4_mb_rd0", 32'(mb_ex_rd0), 32'd0);
        check("t4_s1_rd1", 32'(ex1_ex2_rd1), 32'd0);
        check("t4_wb_rd0", 32'(ex2_wb_rd0), 32'd12);
        check("t4_wb_rd1", 32'(ex2_wb_rd1), 32'd13);
        idle_inputs();
        tick();

        // r0 destinations: ready but never written back.
        issue(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
        tick();
        check("t5_mb_v0", 32'(mb_ex_data_0_valid), 32'd1);
        check("t5_mb_v1", 32'(mb_ex_data_1_valid), 32'd1);
        check("t5_mb_rd0", 32'(mb_ex_rd0), 32'd0);
        idle_inputs();
        repeat (2) tick();
        check("t5_s2_v0", 32'(ex2_wb_data_0_valid), 32'd1);
        check("t5_wb_we", 32'(wb_we), 32'd0);

        // Asynchronous reset in the middle of an EX2 stall with S2 occupied.
        issue(5'd20, 5'd21, 2'b11, 32'h20, 32'h21);
        tick();
        issue(5'd22, 5'd23, 2'b11, 32'h22, 32'h23);
        tick();
        issue(5'd24, 5'd25, 2'b11, 32'h24, 32'h25);
        tick();
        check("t6_pre_wb_we", 32'(wb_we), 32'd3);
        idle_inputs();
        ex2_stall = 1;
        #2;
        rst = 1;
        model_clear();
        #1;
        check("t6_rst_wb_we", 32'(wb_we), 32'd0);
        check("t6_rst_mb_rd0", 32'(mb_ex_rd0), 32'd0);
        check("t6_rst_s1_rd1", 32'(ex1_ex2_rd1), 32'd0);
        check("t6_rst_s2_data0", ex2_wb_data_0, 32'd0);
        check("t6_rst_mb_v0", 32'(mb_ex_data_0_valid), 32'd0);
        issue(5'd26, 5'd27, 2'b11, 32'h26, 32'h27);
        tick();
        rst = 0;
        idle_inputs();
        tick();
        check("t6_post_mb_rd0", 32'(mb_ex_rd0), 32'd0);

        // Randomized traffic checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            id_valid       = ($urandom_range(0, 3) != 0);
            id_rd0         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            id_rd1         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            id_ready       = 2'($urandom);
            id_data0       = $urandom;
            id_data1       = $urandom;
            ex1_res_valid  = 2'($urandom);
            ex1_res0       = $urandom;
            ex1_res1       = $urandom;
            ex2_fill_valid = 2'($urandom);
            ex2_fill0      = $urandom;
            ex2_fill1      = $urandom;
            ex1_stall      = ($urandom_range(0, 6) == 0);
            ex2_stall      = ($urandom_range(0, 6) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            tick();
        end

        idle_inputs();
        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
